regfile_wb_sched: RTL and testbench
===================================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 ADDR_W, default 5, register-address width; 32 architectural registers, register 0 hardwired to zero.
REQ-002 DATA_W, default 32, write-data width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 AValid  input  1  writeback request from ALU path (requester A).
REQ-006 ARd  input  ADDR_W  destination register of request A.
REQ-007 AData  input  DATA_W  write data of request A.
REQ-008 AReady  output  1  request A accepted this cycle.
REQ-009 BValid  input  1  writeback request from load path (requester B).
REQ-010 BRd  input  ADDR_W  destination register of request B.
REQ-011 BData  input  DATA_W  write data of request B.
REQ-012 BReady  output  1  request B accepted this cycle.
REQ-013 ClaimEn  input  1  issue stage reserves destination ClaimRd.
REQ-014 ClaimRd  input  ADDR_W  register being reserved.
REQ-015 RS1, RS2  input  ADDR_W each  source registers of the instruction in issue.
REQ-016 Hazard  output  1  RS1 or RS2 has a pending write.
REQ-017 Busy  output  32  per-register pending-write scoreboard.
REQ-018 RD, WData, RegWr  output  ADDR_W / DATA_W / 1  register-file write port.

Function
REQ-019 Handshake: a request transfers when Valid and Ready are both 1; Ready is combinational from Valid and the arbitration state, never from its own data.
REQ-020 Exactly one of AReady/BReady is 1 when either Valid is 1; both are 0 when neither Valid is 1.
REQ-021 Arbitration: a single valid requester always wins; when both are valid, the requester not granted at the last contention wins (round robin), and the pointer updates only on contention.
REQ-022 The winner is registered into RD/WData at the next rising edge; RegWr is 1 in the following cycle (latency 1) iff a transfer occurred and its Rd != 0.
REQ-023 A transfer with Rd == 0 is accepted (Ready = 1) but produces RegWr = 0 and no scoreboard change.
REQ-024 Cycles without a transfer drive RegWr = 0 and leave RD/WData holding their last values.
REQ-025 Scoreboard: ClaimEn with ClaimRd != 0 sets Busy[ClaimRd]; a committed write (RegWr = 1) clears Busy[RD].
REQ-026 A claim and a commit to the same register in the same cycle leave Busy set (claim wins).
REQ-027 Claims with ClaimRd == 0 are ignored; Busy[0] is constant 0.
REQ-028 Hazard = Busy[RS1] | Busy[RS2], combinational; source register 0 never raises Hazard.

Reset
REQ-029 While Reset = 0: RegWr = 0, RD = 0, WData = 0, Busy = 0, and the arbitration pointer favours A, all independent of Clk.
REQ-030 A request or claim in flight when Reset asserts is discarded; after Reset deasserts, the first rising edge operates normally.

Configuration
REQ-031 Macro WB_ROUND_ROBIN_EN defined: arbitration per REQ-021; undefined: fixed priority with A always winning contention, and the pointer register is not implemented.

Structure
REQ-032 ADDR_W/DATA_W defaults, register count (32) and requester index constants (REQ_A = 0, REQ_B = 1) live in the shared regfile definitions header.
REQ-033 The scoreboard (REQ-025..REQ-028) is a sub-module, wb_scoreboard; arbitration and the output register stay in the top module.

Verification
REQ-034 Reset low, then high; AValid=1, ARd=5, AData=0x11 for one cycle -> AReady=1; next cycle RegWr=1, RD=5, WData=0x11.
REQ-035 AValid and BValid both held for 4 cycles with ARd=3, BRd=4 and round robin enabled -> grants A,B,A,B; without the macro -> A,A,A,A with BReady=0.
REQ-036 ClaimEn with ClaimRd=7, then RS1=7 -> Hazard=1; B writes Rd=7 -> Busy[7] clears the cycle after the write is accepted and Hazard=0.
REQ-037 Claim of Rd=9 in the same cycle as a commit to Rd=9 -> Busy[9]=1 afterwards.
REQ-038 AValid with ARd=0 -> AReady=1, RegWr stays 0; ClaimRd=0 -> Busy unchanged.
REQ-039 Reset asserted mid-stream with Busy=0x00F0 and a pending transfer -> immediately Busy=0 and RegWr=0; the next contention after release grants A.

Source files
------------

// File: rtl/regfile_wb_sched_pkg.sv
// regfile_wb_sched_pkg: shared register-file widths, register count and requester indices
package regfile_wb_sched_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NREGS = 32;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/regfile_wb_sched_scoreboard.sv
// wb_scoreboard: per-register pending-write bits, claim-over-commit priority, source hazard detect
module wb_scoreboard
  import regfile_wb_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClaimEn,
  input  logic [ADDR_W-1:0] ClaimRd,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] RD,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [NREGS-1:0]  Busy,
  output logic              Hazard
);
  logic [NREGS-1:0] busy_q, busy_d;
  // commit clears, claim applied after so it wins; register 0 is never busy
  always_comb begin
    busy_d = busy_q;
    if (RegWr) busy_d[RD] = 1'b0;
    if (ClaimEn) busy_d[ClaimRd] = 1'b1;
    busy_d[0] = 1'b0;
  end
  // scoreboard state
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) busy_q <= '0;
    else busy_q <= busy_d;
  assign Busy = busy_q;
  assign Hazard = busy_q[RS1] | busy_q[RS2];
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: two-requester writeback arbiter with registered RF write port; WB_ROUND_ROBIN_EN selects round robin over fixed A priority
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AValid,
  input  logic [ADDR_W-1:0] ARd,
  input  logic [DATA_W-1:0] AData,
  output logic              AReady,
  input  logic              BValid,
  input  logic [ADDR_W-1:0] BRd,
  input  logic [DATA_W-1:0] BData,
  output logic              BReady,
  input  logic              ClaimEn,
  input  logic [ADDR_W-1:0] ClaimRd,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic              Hazard,
  output logic [NREGS-1:0]  Busy,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WData,
  output logic              RegWr
);
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwr_q, regwr_d;
`ifdef WB_ROUND_ROBIN_EN
  logic prio_q, prio_d;
  // grant: prio_q names the winner of the next contention, flipped only on contention
  always_comb begin
    AReady = AValid & (~BValid | (prio_q == REQ_A));
    BReady = BValid & ~AReady;
    prio_d = (AValid & BValid) ? (AReady ? REQ_B : REQ_A) : prio_q;
  end
  // round-robin pointer
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) prio_q <= REQ_A;
    else prio_q <= prio_d;
`else
  // grant: fixed priority, A wins contention
  always_comb begin
    AReady = AValid;
    BReady = BValid & ~AValid;
  end
`endif
  // winner capture; idle cycles hold RD/WData and drop RegWr, writes to r0 are swallowed
  always_comb begin
    rd_d = AReady ? ARd : BReady ? BRd : rd_q;
    wdata_d = AReady ? AData : BReady ? BData : wdata_q;
    regwr_d = (AReady | BReady) & (rd_d != '0);
  end
  // write-port register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      rd_q <= '0;
      wdata_q <= '0;
      regwr_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wdata_q <= wdata_d;
      regwr_q <= regwr_d;
    end
  assign RD = rd_q;
  assign WData = wdata_q;
  assign RegWr = regwr_q;
  wb_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .Clk(Clk), .Reset(Reset), .ClaimEn(ClaimEn), .ClaimRd(ClaimRd),
    .RegWr(regwr_q), .RD(rd_q), .RS1(RS1), .RS2(RS2), .Busy(Busy), .Hazard(Hazard)
  );
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed stimulus with a writeback scoreboard queue and a decoupled monitor
module tb_regfile_wb_sched;
  logic        Clk = 1'b0, Reset = 1'b0;
  logic        AValid = 1'b0, BValid = 1'b0, ClaimEn = 1'b0;
  logic [4:0]  ARd = '0, BRd = '0, ClaimRd = '0, RS1 = '0, RS2 = '0;
  logic [31:0] AData = '0, BData = '0;
  logic        AReady, BReady, Hazard, RegWr;
  logic [31:0] Busy, WData;
  logic [4:0]  RD;
  logic [36:0] exp_q[$];
  int          errs = 0, checks = 0;
  bit          rr;

  regfile_wb_sched #(.ADDR_W(5), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .AValid(AValid), .ARd(ARd), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BRd(BRd), .BData(BData), .BReady(BReady), .ClaimEn(ClaimEn),
    .ClaimRd(ClaimRd), .RS1(RS1), .RS2(RS2), .Hazard(Hazard), .Busy(Busy), .RD(RD),
    .WData(WData), .RegWr(RegWr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
`ifdef WB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    #12;
    chk("rst_regwr", {31'b0, RegWr}, 32'h0);
    chk("rst_rd", {27'b0, RD}, 32'h0);
    chk("rst_wdata", WData, 32'h0);
    chk("rst_busy", Busy, 32'h0);
    Reset = 1'b1;
    fork
      forever begin
        logic [36:0] e;
        @(negedge Clk);
        if (RegWr === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h want no write", RD, WData);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", {27'b0, RD}, {27'b0, e[36:32]});
            chk("wb_data", WData, e[31:0]);
          end
        end
      end
    join_none
    cyc();
    AValid = 1'b1; ARd = 5'd5; AData = 32'h11;
    #1;
    chk("a_single_ready", {31'b0, AReady}, 32'h1);
    chk("a_single_bready", {31'b0, BReady}, 32'h0);
    exp_q.push_back({5'd5, 32'h11});
    cyc();
    AValid = 1'b0;
    #1;
    chk("idle_aready", {31'b0, AReady}, 32'h0);
    chk("idle_bready", {31'b0, BReady}, 32'h0);
    cyc();
    chk("hold_regwr", {31'b0, RegWr}, 32'h0);
    chk("hold_rd", {27'b0, RD}, 32'h5);
    chk("hold_wdata", WData, 32'h11);
    for (int i = 0; i < 4; i++) begin
      bit ga;
      cyc();
      AValid = 1'b1; BValid = 1'b1; ARd = 5'd3; BRd = 5'd4;
      AData = 32'hA0 + i; BData = 32'hB0 + i;
      ga = rr ? (i % 2 == 0) : 1'b1;
      #1;
      chk("cont_aready", {31'b0, AReady}, {31'b0, ga});
      chk("cont_bready", {31'b0, BReady}, {31'b0, ~ga});
      exp_q.push_back(ga ? {5'd3, 32'hA0 + i} : {5'd4, 32'hB0 + i});
    end
    cyc();
    AValid = 1'b0; BValid = 1'b0;
    ClaimEn = 1'b1; ClaimRd = 5'd7;
    cyc();
    ClaimEn = 1'b0; RS1 = 5'd7;
    #1;
    chk("claim7_busy", Busy, 32'h80);
    chk("claim7_hazard", {31'b0, Hazard}, 32'h1);
    BValid = 1'b1; BRd = 5'd7; BData = 32'h77;
    #1;
    chk("b7_bready", {31'b0, BReady}, 32'h1);
    exp_q.push_back({5'd7, 32'h77});
    cyc();
    BValid = 1'b0;
    #1;
    chk("b7_commit_hazard", {31'b0, Hazard}, 32'h1);
    cyc();
    chk("b7_cleared_busy", Busy, 32'h0);
    chk("b7_cleared_hazard", {31'b0, Hazard}, 32'h0);
    RS1 = 5'd0;
    AValid = 1'b1; ARd = 5'd9; AData = 32'h99;
    exp_q.push_back({5'd9, 32'h99});
    cyc();
    AValid = 1'b0; ClaimEn = 1'b1; ClaimRd = 5'd9;
    cyc();
    ClaimEn = 1'b0;
    chk("claim_wins_busy", Busy, 32'h200);
    AValid = 1'b1; ARd = 5'd0; AData = 32'h55;
    ClaimEn = 1'b1; ClaimRd = 5'd0;
    #1;
    chk("r0_aready", {31'b0, AReady}, 32'h1);
    cyc();
    AValid = 1'b0; ClaimEn = 1'b0;
    chk("r0_regwr", {31'b0, RegWr}, 32'h0);
    chk("r0_claim_busy", Busy, 32'h200);
    AValid = 1'b1; ARd = 5'd9; AData = 32'h9A;
    exp_q.push_back({5'd9, 32'h9A});
    cyc();
    AValid = 1'b0;
    cyc();
    chk("clear9_busy", Busy, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ClaimEn = 1'b1; ClaimRd = 5'(4 + i);
      cyc();
    end
    ClaimEn = 1'b0;
    chk("claims_busy", Busy, 32'hF0);
    AValid = 1'b1; BValid = 1'b1; ARd = 5'd10; BRd = 5'd11; AData = 32'hAA; BData = 32'hBB;
    #1;
    chk("pre_rst_aready", {31'b0, AReady}, 32'h1);
    exp_q.push_back({5'd10, 32'hAA});
    cyc();
    AValid = 1'b0; BValid = 1'b0;
    cyc();
    AValid = 1'b1; ARd = 5'd6; AData = 32'h66;
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_busy", Busy, 32'h0);
    chk("midrst_regwr", {31'b0, RegWr}, 32'h0);
    chk("midrst_rd", {27'b0, RD}, 32'h0);
    chk("midrst_wdata", WData, 32'h0);
    AValid = 1'b0;
    #1;
    Reset = 1'b1;
    cyc();
    AValid = 1'b1; BValid = 1'b1; ARd = 5'd12; BRd = 5'd13; AData = 32'hC1; BData = 32'hD1;
    #1;
    chk("post_rst_aready", {31'b0, AReady}, 32'h1);
    chk("post_rst_bready", {31'b0, BReady}, 32'h0);
    exp_q.push_back({5'd12, 32'hC1});
    cyc();
    AValid = 1'b0; BValid = 1'b0;
    cyc();
    cyc();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
